multi_delay_timer: RTL and testbench

Multi-channel programmable digital delay timer. Each channel has its own trigger, 2-bit mode and delay count, and drives one active-low output. All channels share one programmable tick prescaler. The block is the parametrised successor to the single-channel delay timer: it adds per-channel modes, retriggering, cancellation, a busy flag and an optional input synchroniser.

---
 rtl/multi_delay_timer.sv | 186 ++++++++++++++++++
 tb/tb_multi_delay_timer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_delay_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_delay_timer: NUM_CH delay timers (delay-on/off, one-shot, retrig.)    |
// | sharing one tick prescaler. MULTI_DELAY_TIMER_SYNC_EN adds a 2-flop sync.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module multi_delay_timer #(
  parameter int NUM_CH           = 4,
  parameter int WEIGHT_BIT_WIDTH = 8,
  parameter int PRESCALE_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH-1:0]                  trigger_in,
  input  logic [NUM_CH-1:0]                  mode_a,
  input  logic [NUM_CH-1:0]                  mode_b,
  input  logic [NUM_CH*WEIGHT_BIT_WIDTH-1:0] weighted_bits,
  input  logic [PRESCALE_WIDTH-1:0]          prescale,
  output logic [NUM_CH-1:0]                  delay_out_n,
  output logic [NUM_CH-1:0]                  busy
);

  localparam int W = WEIGHT_BIT_WIDTH;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  localparam logic [1:0] MODE_DON  = 2'b00;
  localparam logic [1:0] MODE_DOFF = 2'b01;
  localparam logic [1:0] MODE_OS   = 2'b10;
  localparam logic [1:0] MODE_ROS  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] trig_prev;
  logic [NUM_CH-1:0] rise;

`ifdef MULTI_DELAY_TIMER_SYNC_EN
  logic [NUM_CH-1:0] sync_q1;
  logic [NUM_CH-1:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= trigger_in;
      sync_q2 <= sync_q1;
    end
  end

  assign trig = sync_q2;
`else
  assign trig = trigger_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_prev <= '0;
    else        trig_prev <= trig;
  end

  assign rise = trig & ~trig_prev;

  // >= rather than == so lowering P below the running count cannot stall ticks.
  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic                      tick;

  assign tick = (presc_cnt >= prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t       state;
    logic [1:0]   mode;
    logic [W-1:0] cnt;
    logic [W-1:0] n_val;
    logic         n_zero;
    logic         out_n_q;
    logic         busy_q;

    assign n_val          = weighted_bits[i*W +: W];
    assign n_zero         = (n_val == '0);
    assign delay_out_n[i] = out_n_q;
    assign busy[i]        = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_IDLE;
        mode    <= MODE_DON;
        cnt     <= '0;
        out_n_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Mode tracks the inputs while idle, so it is frozen on exit.
            mode <= {mode_b[i], mode_a[i]};
            case ({mode_b[i], mode_a[i]})
              MODE_DON: begin
                if (trig[i]) begin
                  busy_q <= 1'b1;
                  cnt    <= n_val;
                  if (n_zero) begin
                    state   <= ST_ACTIVE;
                    out_n_q <= 1'b0;
                  end else begin
                    state   <= ST_WAIT;
                  end
                end
              end
              MODE_DOFF: begin
                if (trig[i]) begin
                  state   <= ST_ACTIVE;
                  out_n_q <= 1'b0;
                  busy_q  <= 1'b1;
                end
              end
              default: begin
                if (rise[i] && !n_zero) begin
                  state   <= ST_HOLD;
                  cnt     <= n_val;
                  out_n_q <= 1'b0;
                  busy_q  <= 1'b1;
                end
              end
            endcase
          end

          ST_WAIT: begin
            if (!trig[i]) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              busy_q <= 1'b0;
            end else if (tick) begin
              cnt <= cnt - CNT_ONE;
              if (cnt == CNT_ONE) begin
                state   <= ST_ACTIVE;
                out_n_q <= 1'b0;
              end
            end
          end

          ST_ACTIVE: begin
            if (!trig[i]) begin
              if (mode == MODE_DOFF && !n_zero) begin
                state <= ST_HOLD;
                cnt   <= n_val;
              end else begin
                state   <= ST_IDLE;
                out_n_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end

          ST_HOLD: begin
            // Trigger events take priority over a same-cycle expiry.
            if (mode == MODE_DOFF && trig[i]) begin
              state <= ST_ACTIVE;
              cnt   <= '0;
            end else if (mode == MODE_ROS && rise[i] && !n_zero) begin
              cnt <= n_val;
            end else if (tick) begin
              cnt <= cnt - CNT_ONE;
              if (cnt == CNT_ONE) begin
                state   <= ST_IDLE;
                out_n_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_delay_timer.sv
`default_nettype none
// Scoreboard bench for multi_delay_timer: stimulus pushes expected output-vector
// changes with their cycle window; a negedge monitor pops and compares each change.
module tb_multi_delay_timer;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int PW  = 8;
`ifdef MULTI_DELAY_TIMER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   trigger_in;
  logic [NCH-1:0]   mode_a;
  logic [NCH-1:0]   mode_b;
  logic [NCH*W-1:0] weighted_bits;
  logic [PW-1:0]    prescale;
  logic [NCH-1:0]   delay_out_n;
  logic [NCH-1:0]   busy;

  multi_delay_timer #(.NUM_CH(NCH), .WEIGHT_BIT_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .trigger_in(trigger_in), .mode_a(mode_a), .mode_b(mode_b),
    .weighted_bits(weighted_bits), .prescale(prescale),
    .delay_out_n(delay_out_n), .busy(busy)
  );

  typedef struct {
    int         lo;
    int         hi;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [3:0] exp_out = 4'hF;
  logic [3:0] exp_busy = 4'h0;
  logic       mon_en = 1'b0;
  logic [7:0] prev = 8'hF0;

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int lo, input int hi);
    ev_t e;
    e.lo  = lo;
    e.hi  = hi;
    e.val = {exp_out, exp_busy};
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #200;
  endtask

  task automatic set_n(input int ch, input logic [7:0] v);
    weighted_bits[ch*W +: W] = v;
  endtask

  task automatic pulse3(input int ch);
    repeat (3) begin
      trigger_in[ch] = 1'b1;
      wait_cyc(1);
      trigger_in[ch] = 1'b0;
      wait_cyc(1);
    end
  endtask

  initial begin : monitor
    logic [7:0] cur;
    ev_t        e;
    forever begin
      @(negedge clk);
      cur = {delay_out_n, busy};
      if (mon_en && cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got={out,busy}=%h want=no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.val || cyc < e.lo || cyc > e.hi) begin
            bad++;
            $display("FAIL event cyc=%0d got={out,busy}=%h want=%h in cycles [%0d,%0d]",
                     cyc, cur, e.val, e.lo, e.hi);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stim
    int e;
    int f;
    int r;
    rst_n = 1'b0; trigger_in = '0; mode_a = '0; mode_b = '0;
    weighted_bits = '0; prescale = '0;
    wait_cyc(3);
    total++;
    if ({delay_out_n, busy} !== 8'hF0) begin
      bad++;
      $display("FAIL reset_values got=%h want=f0", {delay_out_n, busy});
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    wait_cyc(2);

    // Ch0 delay-on N=10: 15-cycle trigger, then a 5-cycle pulse that must not fire.
    set_n(0, 8'd10);
    trigger_in[0] = 1'b1; e = cyc + 1 + LAT;
    exp_busy[0] = 1'b1; push(e, e);
    exp_out[0] = 1'b0;  push(e + 10, e + 10);
    wait_cyc(15);
    trigger_in[0] = 1'b0; f = cyc + 1 + LAT;
    exp_out[0] = 1'b1; exp_busy[0] = 1'b0; push(f, f);
    wait_cyc(6);
    trigger_in[0] = 1'b1; e = cyc + 1 + LAT;
    exp_busy[0] = 1'b1; push(e, e);
    wait_cyc(5);
    trigger_in[0] = 1'b0; f = cyc + 1 + LAT;
    exp_busy[0] = 1'b0; push(f, f);
    wait_cyc(16);

    // Ch1 delay-off N=10 with a 4-cycle cancel gap.
    set_n(1, 8'd10); mode_a[1] = 1'b1;
    trigger_in[1] = 1'b1; e = cyc + 1 + LAT;
    exp_out[1] = 1'b0; exp_busy[1] = 1'b1; push(e, e);
    wait_cyc(6);
    trigger_in[1] = 1'b0;
    wait_cyc(4);
    trigger_in[1] = 1'b1;
    wait_cyc(6);
    trigger_in[1] = 1'b0; f = cyc + 1 + LAT;
    exp_out[1] = 1'b1; exp_busy[1] = 1'b0; push(f + 10, f + 10);
    wait_cyc(16);

    // Ch2 one-shot then retriggerable, three edges 2 cycles apart.
    set_n(2, 8'd10); mode_b[2] = 1'b1; mode_a[2] = 1'b0;
    e = cyc + 1 + LAT;
    exp_out[2] = 1'b0; exp_busy[2] = 1'b1; push(e, e);
    exp_out[2] = 1'b1; exp_busy[2] = 1'b0; push(e + 10, e + 10);
    pulse3(2);
    wait_cyc(14);
    mode_a[2] = 1'b1;
    e = cyc + 1 + LAT;
    exp_out[2] = 1'b0; exp_busy[2] = 1'b1; push(e, e);
    exp_out[2] = 1'b1; exp_busy[2] = 1'b0; push(e + 14, e + 14);
    pulse3(2);
    wait_cyc(16);

    // Ch0 one-shot N=4 P=3: pulse width depends on tick phase.
    mode_b[0] = 1'b1; mode_a[0] = 1'b0; set_n(0, 8'd4); prescale = 8'd3;
    trigger_in[0] = 1'b1; e = cyc + 1 + LAT;
    exp_out[0] = 1'b0; exp_busy[0] = 1'b1; push(e, e);
    exp_out[0] = 1'b1; exp_busy[0] = 1'b0; push(e + 13, e + 16);
    wait_cyc(1);
    trigger_in[0] = 1'b0;
    wait_cyc(22);
    set_n(0, 8'd0);
    trigger_in[0] = 1'b1;
    wait_cyc(1);
    trigger_in[0] = 1'b0;
    wait_cyc(10);
    total++;
    if (busy[0] !== 1'b0 || delay_out_n[0] !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_n0 got busy=%b out_n=%b want busy=0 out_n=1", busy[0], delay_out_n[0]);
    end
    prescale = 8'd0;

    // All channels busy, async reset mid-count, restart with triggers held high.
    set_n(0, 8'd20); set_n(1, 8'd5); set_n(2, 8'd30); set_n(3, 8'd8);
    mode_b = 4'b0101; mode_a = 4'b1000;
    trigger_in = 4'hF; e = cyc + 1 + LAT;
    exp_out = 4'b0010; exp_busy = 4'hF; push(e, e);
    exp_out[1] = 1'b0; push(e + 5, e + 5);
    wait_cyc(8 + LAT);
    rst_n = 1'b0;
    exp_out = 4'hF; exp_busy = 4'h0; push(cyc, cyc);
    #1;
    total++;
    if ({delay_out_n, busy} !== 8'hF0) begin
      bad++;
      $display("FAIL async_reset got=%h want=f0", {delay_out_n, busy});
    end
    wait_cyc(2);
    rst_n = 1'b1; r = cyc + 1 + LAT;
    exp_out = 4'b0010; exp_busy = 4'hF; push(r, r);
    exp_out[1] = 1'b0; push(r + 5, r + 5);
    exp_out[0] = 1'b1; exp_busy[0] = 1'b0; push(r + 20, r + 20);
    exp_out[2] = 1'b1; exp_busy[2] = 1'b0; push(r + 30, r + 30);
    wait_cyc(34 + LAT);
    trigger_in = 4'h0; f = cyc + 1 + LAT;
    exp_out[1] = 1'b1; exp_busy[1] = 1'b0; push(f, f);
    exp_out[3] = 1'b1; exp_busy[3] = 1'b0; push(f + 8, f + 8);
    wait_cyc(14);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d still queued want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
